// File: rtl/ludh_status_recorder_pkg.sv
// ludh_status_recorder_pkg
// Shared definitions for the LUD status recorder:
//   - recorder FSM state encodings (REC_IDLE / REC_CAPTURE / REC_DONE)
//   - default widths, with the address width matching the LUD control-word tester
package ludh_status_recorder_pkg;

  localparam int unsigned REC_ADDR_WIDTH = 12;
  localparam int unsigned REC_STAT_WIDTH = 64;
  localparam int unsigned REC_TS_WIDTH   = 16;

  // Encoding 2'b11 is unused; the FSM recovers from it to REC_IDLE.
  typedef enum logic [1:0] {
    REC_IDLE    = 2'b00,
    REC_CAPTURE = 2'b01,
    REC_DONE    = 2'b10
  } rec_state_t;

endpackage

// File: rtl/ludh_rec_bram.sv
// ludh_rec_bram
// Simple dual-port inferred capture RAM: one write port and one registered read port.
// Ports:
//   clk      - clock
//   we       - write enable
//   wr_addr  - write address
//   wr_data  - write data
//   rd_clr   - synchronous clear of the read data register (has priority over rd_en)
//   rd_en    - read enable; when low the read register holds its value
//   rd_addr  - read address
//   rd_data  - registered read data, one cycle after rd_addr/rd_en
module ludh_rec_bram
  import ludh_status_recorder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = REC_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = REC_STAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_clr,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/ludh_status_recorder.sv
// ludh_status_recorder
// Return-path companion to the LUD control-word tester. While START is high it
// captures valid status words into a capture RAM at incrementing addresses until
// the hardware signals completion; while START is low the ZYNQ reads them back.
// Optional build macro: LUDH_REC_TIMESTAMP_EN prepends a saturating capture-cycle
// timestamp to each stored word.
// Ports:
//   CLK_100             - system clock, rising edge
//   RST                 - synchronous active-high reset
//   START               - high: capture phase, low: ZYNQ access phase
//   STATUS_IN           - status word from the LUD hardware
//   STATUS_VALID        - STATUS_IN valid this cycle
//   HW_DONE             - hardware completion bit
//   bram_ZYNQ_REC_addr  - ZYNQ read address
//   bram_ZYNQ_REC_en    - ZYNQ read enable
//   bram_ZYNQ_REC_dout  - ZYNQ read data (1-cycle latency, 0 while START is high)
//   REC_COUNT           - words written in the current or last capture
//   OVERFLOW            - sticky: a valid word was dropped because memory was full
//   RECORDING           - high in CAPTURE
//   debug_state         - current FSM state encoding
module ludh_status_recorder
  import ludh_status_recorder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = REC_ADDR_WIDTH,
  parameter int unsigned STAT_WIDTH = REC_STAT_WIDTH,
  parameter int unsigned TS_WIDTH   = REC_TS_WIDTH,
`ifdef LUDH_REC_TIMESTAMP_EN
  localparam bit          TS_EN      = 1'b1,
`else
  localparam bit          TS_EN      = 1'b0,
`endif
  localparam int unsigned W          = STAT_WIDTH + (TS_EN ? TS_WIDTH : 0)
) (
  input  logic                  CLK_100,
  input  logic                  RST,
  input  logic                  START,
  input  logic [STAT_WIDTH-1:0] STATUS_IN,
  input  logic                  STATUS_VALID,
  input  logic                  HW_DONE,
  input  logic [ADDR_WIDTH-1:0] bram_ZYNQ_REC_addr,
  input  logic                  bram_ZYNQ_REC_en,
  output logic [W-1:0]          bram_ZYNQ_REC_dout,
  output logic [ADDR_WIDTH:0]   REC_COUNT,
  output logic                  OVERFLOW,
  output logic                  RECORDING,
  output logic [1:0]            debug_state
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  rec_state_t            state;
  rec_state_t            state_nxt;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   rec_count;
  logic                  overflow;
  logic                  recording;
  logic                  start_cap;
  logic                  full;
  logic                  we;
  logic [W-1:0]          wr_data;

  assign start_cap = (state == REC_IDLE) && START;
  assign full      = (rec_count == DEPTH_CNT);
  assign we        = (state == REC_CAPTURE) && STATUS_VALID && !full;

  always_comb begin
    state_nxt = REC_IDLE;
    case (state)
      REC_IDLE:    state_nxt = START ? REC_CAPTURE : REC_IDLE;
      // Dropping START aborts the capture even if HW_DONE arrives together.
      REC_CAPTURE: state_nxt = !START ? REC_IDLE : (HW_DONE ? REC_DONE : REC_CAPTURE);
      REC_DONE:    state_nxt = START ? REC_DONE : REC_IDLE;
      default:     state_nxt = REC_IDLE;
    endcase
  end

  always_ff @(posedge CLK_100) begin
    if (RST) begin
      state     <= REC_IDLE;
      recording <= 1'b0;
      wr_addr   <= '0;
      rec_count <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      recording <= (state_nxt == REC_CAPTURE);
      if (start_cap) begin
        wr_addr   <= '0;
        rec_count <= '0;
        overflow  <= 1'b0;
      end else if ((state == REC_CAPTURE) && STATUS_VALID) begin
        if (!full) begin
          rec_count <= rec_count + 1'b1;
          // Address parks on the last word instead of wrapping; the full
          // check stops any further write.
          if (wr_addr != '1) begin
            wr_addr <= wr_addr + 1'b1;
          end
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

`ifdef LUDH_REC_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts;

  // Holds 0 during the first CAPTURE cycle, then counts CAPTURE cycles.
  always_ff @(posedge CLK_100) begin
    if (RST) begin
      ts <= '0;
    end else if (start_cap) begin
      ts <= '0;
    end else if ((state == REC_CAPTURE) && (ts != '1)) begin
      ts <= ts + 1'b1;
    end
  end

  assign wr_data = {ts, STATUS_IN};
`else
  assign wr_data = STATUS_IN;
`endif

  ludh_rec_bram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (W)
  ) u_bram (
    .clk     (CLK_100),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_clr  (RST | START),
    .rd_en   (bram_ZYNQ_REC_en),
    .rd_addr (bram_ZYNQ_REC_addr),
    .rd_data (bram_ZYNQ_REC_dout)
  );

  assign REC_COUNT   = rec_count;
  assign OVERFLOW    = overflow;
  assign RECORDING   = recording;
  assign debug_state = state;

endmodule

// File: doc/ludh_status_recorder.md
Name: ludh_status_recorder

Overview:
- Return-path companion to the LUD control-word tester.
- While START is high, captures per-cycle status words from the LUD hardware into an internal capture BRAM at incrementing addresses.
- While START is low, the ZYNQ reads the captured words back over a BRAM-style port.
- Sits beside the tester, shares CLK_100 and START, and stops capturing when the hardware asserts its completion bit.

Parameters:
- ADDR_WIDTH, 12, capture memory address width; DEPTH = 2^ADDR_WIDTH words.
- STAT_WIDTH, 64, width of one status word from the LUD hardware.
- TS_WIDTH, 16, timestamp field width; used only with the optional feature.

Ports:
- CLK_100  input  1  single system clock; all logic on its rising edge.
- RST  input  1  reset, synchronous, active-high.
- START  input  1  run request, same signal the tester uses; high = capture phase, low = ZYNQ access phase.
- STATUS_IN  input  STAT_WIDTH  status word from the LUD hardware.
- STATUS_VALID  input  1  STATUS_IN is valid this cycle.
- HW_DONE  input  1  hardware completion bit (control word bit 0).
- bram_ZYNQ_REC_addr  input  ADDR_WIDTH  ZYNQ read address.
- bram_ZYNQ_REC_en  input  1  ZYNQ read enable.
- bram_ZYNQ_REC_dout  output  W  read data. W = STAT_WIDTH, or TS_WIDTH+STAT_WIDTH with the optional feature.
- REC_COUNT  output  ADDR_WIDTH+1  number of words written in the current or last capture.
- OVERFLOW  output  1  sticky; at least one valid word was dropped because memory was full.
- RECORDING  output  1  high in CAPTURE state.
- debug_state  output  2  current FSM state encoding.

Behaviour:
- Reset (RST=1 at a clock edge):
  - State goes to IDLE.
  - REC_COUNT=0, OVERFLOW=0, RECORDING=0, write address=0, bram_ZYNQ_REC_dout=0.
  - Memory contents are not cleared.
- FSM states: IDLE=2'b00, CAPTURE=2'b01, DONE=2'b10. Encoding 2'b11 is illegal and returns to IDLE next cycle.
- IDLE:
  - START=1 -> CAPTURE.
  - On that transition, clear write address, REC_COUNT and OVERFLOW.
- CAPTURE:
  - Each cycle with STATUS_VALID=1 and REC_COUNT<DEPTH: mem[wr_addr] <= word, wr_addr++, REC_COUNT++.
  - Each cycle with STATUS_VALID=1 and REC_COUNT==DEPTH: drop the word and set OVERFLOW. The write address never wraps.
  - HW_DONE=1 -> DONE. A valid word presented in the same cycle is still written, subject to the capacity rule.
  - START=0 -> IDLE. This has priority over HW_DONE.
- DONE:
  - No writes.
  - START=0 -> IDLE; otherwise stay in DONE.
- Hold rules: REC_COUNT and OVERFLOW keep their values in DONE and IDLE, so the ZYNQ can read the result length after START drops. They are cleared only by RST or by the next IDLE->CAPTURE transition.
- ZYNQ read port:
  - Active only when START=0.
  - Read latency is 1 cycle: addr/en sampled at edge N, data valid after edge N+1.
  - With en=0, dout holds its previous value.
  - While START=1, dout is forced to 0 and ZYNQ requests are ignored.
- Write data width: STATUS_IN is written unmodified.
- No read/write collision is possible, because the capture and ZYNQ phases are mutually exclusive on START.
- RECORDING = (state==CAPTURE), registered with the state.

Optional Feature:
- Macro: LUDH_REC_TIMESTAMP_EN.
- Defined:
  - A TS_WIDTH-bit cycle counter clears on IDLE->CAPTURE and increments every CAPTURE cycle, saturating at all-ones.
  - Each stored word is {timestamp, STATUS_IN}, so W = TS_WIDTH+STAT_WIDTH.
  - The timestamp of the first CAPTURE cycle is 0.
- Undefined: no counter exists and W = STAT_WIDTH.

Decomposition:
- Shared package:
  - State encodings REC_IDLE/REC_CAPTURE/REC_DONE.
  - Default width constants, aligned with the tester's ADDR_WIDTH.
- One sub-module: ludh_rec_bram.
  - Simple dual-port inferred RAM: one write port, one registered read port, on CLK_100.
  - Width W, depth 2^ADDR_WIDTH.

Test Plan:
- Basic capture:
  - Stimulus: ADDR_WIDTH=4; START=1; 5 valid words 0x11..0x15; HW_DONE on the 5th word; then START=0; read addresses 0..4.
  - Response: REC_COUNT=5, state DONE, reads return 0x11..0x15 one cycle after each address.
- Gapped valid:
  - Stimulus: STATUS_VALID pattern 1,0,1,1,0,1 with data A,-,B,C,-,D.
  - Response: mem[0..3]=A,B,C,D; REC_COUNT=4.
- Overflow:
  - Stimulus: ADDR_WIDTH=4; 20 consecutive valid words.
  - Response: REC_COUNT=16, OVERFLOW=1 from the 17th word on; mem[15]=16th word; mem[0] not overwritten.
- Abort:
  - Stimulus: START drops mid-capture after 3 words.
  - Response: IDLE next cycle, REC_COUNT stays 3.
  - Stimulus: raise START again.
  - Response: REC_COUNT=0 and OVERFLOW=0 at the first CAPTURE cycle.
- Reset and read-port gating:
  - Stimulus: RST pulsed in CAPTURE.
  - Response: all outputs at reset values next cycle.
  - Stimulus: ZYNQ reads while START=1.
  - Response: dout=0.
- LUDH_REC_TIMESTAMP_EN defined:
  - Stimulus: valid words on CAPTURE cycles 0, 2 and 3.
  - Response: stored timestamps 0, 2, 3 in the upper TS_WIDTH bits.
